// File: rtl/fm_param_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fm_param_sequencer
// Purpose  : Accepts FM voice parameter commands (fundamental, harmonicity,
//            modulation index, modulation step) and applies them to the synth
//            on sample ticks. Fundamental and harmonicity change in one step on
//            the first tick after a command. The modulation index then ramps
//            toward its target by one step per tick.
// Ports    : clk, reset        - clock and asynchronous active-high reset
//            sample_tick       - one-cycle pulse per synth output sample
//            cmd_valid/ready   - command handshake (ready only when idle)
//            cmd_fundamental   - target fundamental, unsigned Q14.10 Hz
//            cmd_harmonicity   - target harmonicity, unsigned Q3.13
//            cmd_mod_index     - target modulation index, unsigned Q7.9
//            cmd_mod_step      - index change per tick, 0 = jump
//            fundamental, harmonicity, mod_index - registered synth params
//            busy              - a command is in progress
//            done              - one-cycle pulse after a command completes
// Revision : 1.0 - initial release
// ============================================================================
module fm_param_sequencer #(
  parameter int FUND_WIDTH = 24,
  parameter int HARM_WIDTH = 16,
  parameter int IDX_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [FUND_WIDTH-1:0] cmd_fundamental,
  input  logic [HARM_WIDTH-1:0] cmd_harmonicity,
  input  logic [IDX_WIDTH-1:0]  cmd_mod_index,
  input  logic [IDX_WIDTH-1:0]  cmd_mod_step,
  output logic [FUND_WIDTH-1:0] fundamental,
  output logic [HARM_WIDTH-1:0] harmonicity,
  output logic [IDX_WIDTH-1:0]  mod_index,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] C_IDLE      = 2'd0;
  localparam logic [1:0] C_WAIT_TICK = 2'd1;
  localparam logic [1:0] C_RAMP      = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [FUND_WIDTH-1:0] fund_q, tgt_fund_q;
  logic [HARM_WIDTH-1:0] harm_q, tgt_harm_q;
  logic [IDX_WIDTH-1:0]  idx_q, tgt_idx_q, tgt_step_q;
  logic                  done_q;
  // Low while reset is held and until the first edge after release, so
  // cmd_ready stays low during reset even though the state reads IDLE.
  logic                  live_q;

  logic                  w_handshake;
  logic                  w_active;
  logic                  w_tick_step;
  logic                  w_up;
  logic                  w_reach;
  logic [IDX_WIDTH:0]    w_cur, w_tgt, w_stp, w_diff, w_next_ext;

  assign w_handshake = cmd_valid && cmd_ready;
  assign w_active    = (state_q == C_WAIT_TICK) || (state_q == C_RAMP);
  assign w_tick_step = sample_tick && w_active;

  // One ramp step, evaluated one bit wider than the index so neither the
  // distance nor the moved value can wrap. Moving by the full step only when
  // the distance exceeds it guarantees no overshoot past the target.
  always_comb begin
    w_cur = {1'b0, idx_q};
    w_tgt = {1'b0, tgt_idx_q};
    w_stp = {1'b0, tgt_step_q};
    w_up  = (w_tgt >= w_cur);
    w_diff = w_up ? (w_tgt - w_cur) : (w_cur - w_tgt);
    if ((w_stp == '0) || (w_diff <= w_stp)) begin
      w_next_ext = w_tgt;
    end else if (w_up) begin
      w_next_ext = w_cur + w_stp;
    end else begin
      w_next_ext = w_cur - w_stp;
    end
    w_reach = (w_next_ext == w_tgt);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE: begin
        if (w_handshake) state_d = C_WAIT_TICK;
      end
      C_WAIT_TICK, C_RAMP: begin
        if (sample_tick) state_d = w_reach ? C_IDLE : C_RAMP;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = live_q && (state_q == C_IDLE);
    busy      = (state_q != C_IDLE);
  end

  // Datapath: target capture, parameter updates and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q     <= 1'b0;
      done_q     <= 1'b0;
      fund_q     <= '0;
      harm_q     <= '0;
      idx_q      <= '0;
      tgt_fund_q <= '0;
      tgt_harm_q <= '0;
      tgt_idx_q  <= '0;
      tgt_step_q <= '0;
    end else begin
      live_q <= 1'b1;
      done_q <= w_tick_step && w_reach;
      if (w_handshake) begin
        tgt_fund_q <= cmd_fundamental;
        tgt_harm_q <= cmd_harmonicity;
        tgt_idx_q  <= cmd_mod_index;
        tgt_step_q <= cmd_mod_step;
      end
      // Fundamental and harmonicity only move on the first tick of a command
      if (sample_tick && (state_q == C_WAIT_TICK)) begin
        fund_q <= tgt_fund_q;
        harm_q <= tgt_harm_q;
      end
      if (w_tick_step) begin
        idx_q <= w_next_ext[IDX_WIDTH-1:0];
      end
    end
  end

  assign fundamental = fund_q;
  assign harmonicity = harm_q;
  assign mod_index   = idx_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fm_param_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fm_param_sequencer
// Purpose  : Directed self-checking bench for fm_param_sequencer: reset,
//            jump, ramp up/down, extremes, handshake/tick collision, commands
//            during a ramp and reset in the middle of a ramp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fm_param_sequencer;

  logic        clk;
  logic        reset;
  logic        sample_tick;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_fundamental;
  logic [15:0] cmd_harmonicity;
  logic [15:0] cmd_mod_index;
  logic [15:0] cmd_mod_step;
  logic [23:0] fundamental;
  logic [15:0] harmonicity;
  logic [15:0] mod_index;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  fm_param_sequencer #(
    .FUND_WIDTH(24),
    .HARM_WIDTH(16),
    .IDX_WIDTH (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_tick    (sample_tick),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_fundamental(cmd_fundamental),
    .cmd_harmonicity(cmd_harmonicity),
    .cmd_mod_index  (cmd_mod_index),
    .cmd_mod_step   (cmd_mod_step),
    .fundamental    (fundamental),
    .harmonicity    (harmonicity),
    .mod_index      (mod_index),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs are changed and outputs sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
  endtask

  task automatic check_params(input string tag, input logic [23:0] f,
                              input logic [15:0] h, input logic [15:0] i);
    check({tag, "_fund"}, 32'(fundamental), 32'(f));
    check({tag, "_harm"}, 32'(harmonicity), 32'(h));
    check({tag, "_idx"},  32'(mod_index),   32'(i));
  endtask

  // Issue one command; optionally pulse sample_tick in the handshake cycle.
  task automatic send(input string tag, input logic [23:0] f, input logic [15:0] h,
                      input logic [15:0] i, input logic [15:0] s, input logic with_tick);
    for (int k = 0; k < 20 && !cmd_ready; k++) cycle();
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid       = 1'b1;
    cmd_fundamental = f;
    cmd_harmonicity = h;
    cmd_mod_index   = i;
    cmd_mod_step    = s;
    sample_tick     = with_tick;
    cycle();
    sample_tick     = 1'b0;
    cmd_valid       = 1'b0;
    // Fields are not required to hold after the handshake
    cmd_fundamental = 24'($urandom);
    cmd_harmonicity = 16'($urandom);
    cmd_mod_index   = 16'($urandom);
    cmd_mod_step    = 16'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    sample_tick = 1'b0;
    cmd_valid = 1'b0;
    cmd_fundamental = '0;
    cmd_harmonicity = '0;
    cmd_mod_index   = '0;
    cmd_mod_step    = '0;

    // Reset state
    #12;
    check_params("rst", 24'h0, 16'h0, 16'h0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_ready_pre", 32'(cmd_ready), 32'd0);
    cycle();
    check("rel_ready_post", 32'(cmd_ready), 32'd1);

    // Jump
    send("jump", 24'h040000, 16'h2000, 16'h4000, 16'h0000, 1'b0);
    check("jump_busy", 32'(busy), 32'd1);
    check("jump_rdy_lo", 32'(cmd_ready), 32'd0);
    cycle();
    check_params("jump_hold", 24'h0, 16'h0, 16'h0);
    tick();
    check_params("jump", 24'h040000, 16'h2000, 16'h4000);
    check("jump_done", 32'(done), 32'd1);
    check("jump_busy_lo", 32'(busy), 32'd0);
    check("jump_rdy_done", 32'(cmd_ready), 32'd1);
    cycle();
    check("jump_done_1cyc", 32'(done), 32'd0);

    // Bring index to zero, then ramp up
    send("zero", 24'h040000, 16'h2000, 16'h0000, 16'h0000, 1'b0);
    tick();
    check("zero_idx", 32'(mod_index), 32'h0);
    send("up", 24'h050000, 16'h3000, 16'h0A00, 16'h0300, 1'b0);
    tick();
    check_params("up1", 24'h050000, 16'h3000, 16'h0300);
    check("up1_done", 32'(done), 32'd0);
    check("up1_busy", 32'(busy), 32'd1);
    // A command offered mid-ramp must be ignored
    cmd_valid = 1'b1;
    cmd_fundamental = 24'h0ABCDE;
    cmd_harmonicity = 16'h1234;
    cmd_mod_index   = 16'h0000;
    cmd_mod_step    = 16'h0000;
    cycle();
    check("ramp_rdy_lo", 32'(cmd_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    check_params("up2", 24'h050000, 16'h3000, 16'h0600);
    tick();
    check_params("up3", 24'h050000, 16'h3000, 16'h0900);
    check("up3_done", 32'(done), 32'd0);
    tick();
    check_params("up4", 24'h050000, 16'h3000, 16'h0A00);
    check("up4_done", 32'(done), 32'd1);
    cycle();
    check("up4_done_1cyc", 32'(done), 32'd0);

    // Ramp down without wrapping below zero
    send("dn", 24'h050000, 16'h3000, 16'h0000, 16'h0400, 1'b0);
    tick();
    check("dn1", 32'(mod_index), 32'h0600);
    tick();
    check("dn2", 32'(mod_index), 32'h0200);
    check("dn2_done", 32'(done), 32'd0);
    tick();
    check("dn3", 32'(mod_index), 32'h0000);
    check("dn3_done", 32'(done), 32'd1);

    // Extremes: full-scale step reaches full scale in one tick
    send("ext1", 24'hFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    tick();
    check_params("ext1", 24'hFFFFFF, 16'hFFFF, 16'hFFFF);
    check("ext1_done", 32'(done), 32'd1);
    // Distance 0xFFFE exceeds step 0x8000: one step down, then settle
    send("ext2", 24'h000001, 16'h0001, 16'h0001, 16'h8000, 1'b0);
    tick();
    check("ext2_a", 32'(mod_index), 32'h7FFF);
    check("ext2_a_done", 32'(done), 32'd0);
    tick();
    check("ext2_b", 32'(mod_index), 32'h0001);
    check("ext2_b_done", 32'(done), 32'd1);
    // Target equals current index: completes on the first tick
    send("same", 24'h000002, 16'h0002, 16'h0001, 16'h0010, 1'b0);
    tick();
    check_params("same", 24'h000002, 16'h0002, 16'h0001);
    check("same_done", 32'(done), 32'd1);

    // Handshake and tick in the same cycle
    send("coll", 24'h060000, 16'h4000, 16'h0100, 16'h0000, 1'b1);
    check_params("coll_hold", 24'h000002, 16'h0002, 16'h0001);
    check("coll_done", 32'(done), 32'd0);
    check("coll_busy", 32'(busy), 32'd1);
    tick();
    check_params("coll_upd", 24'h060000, 16'h4000, 16'h0100);
    check("coll_upd_done", 32'(done), 32'd1);

    // Reset in the middle of a ramp
    send("rz", 24'h060000, 16'h4000, 16'h0000, 16'h0000, 1'b0);
    tick();
    send("rr", 24'h050000, 16'h3000, 16'h0A00, 16'h0300, 1'b0);
    tick();
    check("rr1", 32'(mod_index), 32'h0300);
    #2 reset = 1'b1;
    #1;
    check_params("rr_async", 24'h0, 16'h0, 16'h0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_ready", 32'(cmd_ready), 32'd0);
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
    check("rr_done", 32'(done), 32'd0);
    check("rr_idx_held", 32'(mod_index), 32'h0);
    #1 reset = 1'b0;
    #1;
    check("rr_rel_pre", 32'(cmd_ready), 32'd0);
    cycle();
    check("rr_rel_post", 32'(cmd_ready), 32'd1);
    check("rr_rel_done", 32'(done), 32'd0);
    check("rr_rel_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
